// File: rtl/vga_driver.sv
// rtl/vga_driver.sv - VGA timing generator with a 2-clock output pipeline; VGA_BORDER_EN forces a white border
// Counters run in pixel clocks; stage 1 registers position flags, stage 2 meets the registered pattern data.
module vga_driver #(
    parameter int H_DISP   = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_DISP   = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic        clk_25m,
    input  logic        rst,
    input  logic [23:0] vga_data,
    output logic [10:0] vga_xpos,
    output logic [10:0] vga_ypos,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_de,
    output logic [23:0] vga_rgb,
    output logic        vga_frame
);

    localparam logic [10:0] H_ACT    = 11'(H_DISP);
    localparam logic [10:0] H_LAST   = 11'(H_DISP + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [10:0] HS_START = 11'(H_DISP + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_DISP + H_FRONT + H_SYNC);
    localparam logic [10:0] V_ACT    = 11'(V_DISP);
    localparam logic [10:0] V_LAST   = 11'(V_DISP + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [10:0] VS_START = 11'(V_DISP + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_DISP + V_FRONT + V_SYNC);

    logic [10:0] h_cnt;
    logic [10:0] v_cnt;
    logic        active;
    logic        in_hsync;
    logic        in_vsync;

    logic        s1_hs;
    logic        s1_vs;
    logic        s1_active;
    logic        s1_first;

    always_ff @(posedge clk_25m or posedge rst) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
        end else begin
            h_cnt <= h_cnt + 11'd1;
        end
    end

    assign active   = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign in_hsync = (h_cnt >= HS_START) && (h_cnt < HS_END);
    assign in_vsync = (v_cnt >= VS_START) && (v_cnt < VS_END);

    // The request goes out now; the pattern block answers one clock later, in step with stage 1.
    assign vga_xpos = active ? h_cnt : 11'd0;
    assign vga_ypos = active ? v_cnt : 11'd0;

`ifdef VGA_BORDER_EN
    logic s1_border;
    logic on_edge;

    assign on_edge = (h_cnt == 11'd0) || (h_cnt == H_ACT - 11'd1) ||
                     (v_cnt == 11'd0) || (v_cnt == V_ACT - 11'd1);

    always_ff @(posedge clk_25m or posedge rst) begin
        if (rst) begin
            s1_border <= 1'b0;
        end else begin
            s1_border <= active && on_edge;
        end
    end
`endif

    always_ff @(posedge clk_25m or posedge rst) begin
        if (rst) begin
            s1_hs     <= ~SYNC_POL;
            s1_vs     <= ~SYNC_POL;
            s1_active <= 1'b0;
            s1_first  <= 1'b0;
        end else begin
            s1_hs     <= in_hsync ? SYNC_POL : ~SYNC_POL;
            s1_vs     <= in_vsync ? SYNC_POL : ~SYNC_POL;
            s1_active <= active;
            s1_first  <= (h_cnt == 11'd0) && (v_cnt == 11'd0);
        end
    end

    always_ff @(posedge clk_25m or posedge rst) begin
        if (rst) begin
            vga_hs    <= ~SYNC_POL;
            vga_vs    <= ~SYNC_POL;
            vga_de    <= 1'b0;
            vga_rgb   <= 24'h000000;
            vga_frame <= 1'b0;
        end else begin
            vga_hs    <= s1_hs;
            vga_vs    <= s1_vs;
            vga_de    <= s1_active;
            vga_frame <= s1_first;
`ifdef VGA_BORDER_EN
            if (s1_border) begin
                vga_rgb <= 24'hFFFFFF;
            end else begin
                vga_rgb <= s1_active ? vga_data : 24'h000000;
            end
`else
            vga_rgb   <= s1_active ? vga_data : 24'h000000;
`endif
        end
    end

endmodule

// File: tb/tb_vga_driver.sv
// tb/tb_vga_driver.sv - directed bench for vga_driver on a reduced 16x6 geometry so whole frames fit in a short run
module tb_vga_driver;

    localparam int HD = 16, HF = 3, HS = 5, HB = 4;
    localparam int HT = HD + HF + HS + HB;
    localparam int VD = 6, VF = 2, VS = 3, VB = 2;
    localparam int VT = VD + VF + VS + VB;
    localparam int FT = HT * VT;

    logic        clk_25m = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] vga_data = 24'h0;
    logic [10:0] vga_xpos;
    logic [10:0] vga_ypos;
    logic        vga_hs;
    logic        vga_vs;
    logic        vga_de;
    logic [23:0] vga_rgb;
    logic        vga_frame;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit data_mode = 1'b0;

    vga_driver #(
        .H_DISP(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISP(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POL(1'b0)
    ) dut (
        .clk_25m(clk_25m),
        .rst(rst),
        .vga_data(vga_data),
        .vga_xpos(vga_xpos),
        .vga_ypos(vga_ypos),
        .vga_hs(vga_hs),
        .vga_vs(vga_vs),
        .vga_de(vga_de),
        .vga_rgb(vga_rgb),
        .vga_frame(vga_frame)
    );

    always #20 clk_25m = ~clk_25m;

    // Pattern block model: registered colour answering the coordinate request
    always @(posedge clk_25m)
        vga_data <= data_mode ? 24'hFFFFFF : {5'b0, vga_ypos, vga_xpos[7:0]};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_25m);
        cyc++;
        #5;
    endtask

    function automatic logic [23:0] exp_rgb(input int x, input int y, input bit mode);
        if (!(x < HD && y < VD)) return 24'h000000;
`ifdef VGA_BORDER_EN
        if (x == 0 || x == HD - 1 || y == 0 || y == VD - 1) return 24'hFFFFFF;
`endif
        return mode ? 24'hFFFFFF : {5'b0, 11'(y), 8'(x)};
    endfunction

    task automatic check_pixel(input bit mode);
        int p, x, y, cx, cy;
        bit act;
        p  = cyc - 2;
        x  = p % HT;
        y  = (p / HT) % VT;
        cx = cyc % HT;
        cy = (cyc / HT) % VT;
        act = (cx < HD) && (cy < VD);
        check("de",    32'(vga_de),    (x < HD && y < VD) ? 1 : 0);
        check("hs",    32'(vga_hs),    (x >= HD + HF && x < HD + HF + HS) ? 0 : 1);
        check("vs",    32'(vga_vs),    (y >= VD + VF && y < VD + VF + VS) ? 0 : 1);
        check("frame", 32'(vga_frame), (x == 0 && y == 0) ? 1 : 0);
        check("rgb",   32'(vga_rgb),   32'(exp_rgb(x, y, mode)));
        check("xpos",  32'(vga_xpos),  act ? cx : 0);
        check("ypos",  32'(vga_ypos),  act ? cy : 0);
    endtask

    initial begin
        int p;
        int de_cnt = 0, hs_cnt = 0, vs_cnt = 0;
        int hs_first = -1, vs_first = -1, last_frame = -1;
        logic [23:0] rgb_53 = 24'h0;

        repeat (10) @(posedge clk_25m);
        #5;
        check("rst_hs",    32'(vga_hs),    1);
        check("rst_vs",    32'(vga_vs),    1);
        check("rst_de",    32'(vga_de),    0);
        check("rst_rgb",   32'(vga_rgb),   0);
        check("rst_frame", 32'(vga_frame), 0);
        check("rst_xpos",  32'(vga_xpos),  0);
        check("rst_ypos",  32'(vga_ypos),  0);

        rst = 1'b0;
        cyc = 0;
        tick();
        check("frame_edge1", 32'(vga_frame), 0);
        check("de_edge1",    32'(vga_de),    0);
        check("xpos_edge1",  32'(vga_xpos),  1);
        tick();
        check("frame_edge2", 32'(vga_frame), 1);
        check("de_edge2",    32'(vga_de),    1);

        while (cyc < 2 + 3 * FT) begin
            p = cyc - 2;
            check_pixel(p >= 2 * FT);
            if (p < HT) begin
                de_cnt += int'(vga_de);
                if (!vga_hs) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = p;
                end
            end
            if (p < FT && !vga_vs) begin
                vs_cnt++;
                if (vs_first < 0) vs_first = p;
            end
            if (p == 3 * HT + 5) rgb_53 = vga_rgb;
            if (vga_frame) begin
                if (last_frame >= 0) check("frame_gap", p - last_frame, FT);
                last_frame = p;
            end
            if (p == 2 * FT - 20) data_mode = 1'b1;
            tick();
        end

        check("line_de_cnt",  de_cnt,   HD);
        check("line_hs_cnt",  hs_cnt,   HS);
        check("line_hs_at",   hs_first, HD + HF);
        check("frame_vs_cnt", vs_cnt,   VS * HT);
        check("frame_vs_at",  vs_first, (VD + VF) * HT);
        check("rgb_5_3",      32'(rgb_53), 32'h000305);
        check("frame_seen",   last_frame, 2 * FT);

        // Mid-frame reset at output pixel (5,2)
        while (cyc < 2 + 3 * FT + 2 * HT + 5) tick();
        check("pre_rst_de", 32'(vga_de), 1);
        rst = 1'b1;
        #1;
        check("async_de",    32'(vga_de),    0);
        check("async_rgb",   32'(vga_rgb),   0);
        check("async_hs",    32'(vga_hs),    1);
        check("async_frame", 32'(vga_frame), 0);
        check("async_xpos",  32'(vga_xpos),  0);
        check("async_ypos",  32'(vga_ypos),  0);
        repeat (3) @(posedge clk_25m);
        #5;
        rst = 1'b0;
        cyc = 0;
        tick();
        check("restart_frame1", 32'(vga_frame), 0);
        tick();
        check("restart_frame2", 32'(vga_frame), 1);
        check("restart_de",     32'(vga_de),    1);
        check("restart_xpos",   32'(vga_xpos),  2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
